// File: rtl/bsg_vanilla_pkg.sv
// bsg_vanilla_pkg: shared instruction types, NOP constant and sequencer FSM states.
package bsg_vanilla_pkg;
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2;
        logic [4:0] rs1;
        logic [2:0] funct3;
        logic [4:0] rd;
        logic [6:0] opcode;
    } instruction_s;

    typedef logic [31:0] instruction_t;

    localparam instruction_t vanilla_nop_gp = 32'h00000013;

    typedef enum logic {eRun, eWait} dual_seq_state_e;
endpackage

// File: rtl/dual_issue_queue.sv
// dual_issue_queue: circular instruction/PC queue with one write port,
// a dual-read head pair and a pop of 0, 1 or 2 entries per cycle.
module dual_issue_queue
    import bsg_vanilla_pkg::*;
#(
    parameter int depth_p    = 4,
    parameter int pc_width_p = 32
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic                    flush_i,
    input  logic                    enq_i,
    input  logic [31:0]             instr_i,
    input  logic [pc_width_p-1:0]   pc_i,
    input  logic [1:0]              pop_i,
    output logic [$clog2(depth_p):0] count_o,
    output logic [31:0]             head_instr_o [2],
    output logic [pc_width_p-1:0]   head_pc_o [2]
);
    localparam int ptr_w_lp = $clog2(depth_p);
    localparam int cnt_w_lp = ptr_w_lp + 1;

    instruction_s          instr_mem [depth_p];
    logic [pc_width_p-1:0] pc_mem [depth_p];
    logic [ptr_w_lp-1:0]   rd_ptr, wr_ptr, rd_ptr_1;

    assign rd_ptr_1        = rd_ptr + ptr_w_lp'(1);
    assign head_instr_o[0] = instr_mem[rd_ptr];
    assign head_instr_o[1] = instr_mem[rd_ptr_1];
    assign head_pc_o[0]    = pc_mem[rd_ptr];
    assign head_pc_o[1]    = pc_mem[rd_ptr_1];

    // Pointers wrap naturally because depth_p is a power of two.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_o <= '0;
        end else begin
            rd_ptr  <= rd_ptr + ptr_w_lp'(pop_i);
            wr_ptr  <= wr_ptr + ptr_w_lp'(enq_i);
            count_o <= count_o + cnt_w_lp'(enq_i) - cnt_w_lp'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq_i) begin
            instr_mem[wr_ptr] <= instr_i;
            pc_mem[wr_ptr]    <= pc_i;
        end
    end
endmodule

// File: rtl/dual_issue_sequencer.sv
// dual_issue_sequencer: presents the queued head pair to the pair decoder and
// issues one or two instructions per cycle, stalling after PC-changing ops.
module dual_issue_sequencer
    import bsg_vanilla_pkg::*;
#(
    parameter int depth_p    = 4,
    parameter int pc_width_p = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  fetch_v_i,
    input  logic [31:0]           fetch_instr_i,
    input  logic [pc_width_p-1:0] fetch_pc_i,
    output logic                  fetch_ready_o,
    output logic [31:0]           pair_instr_o [2],
    output logic [1:0]            pair_v_o,
    input  logic                  single_issue_i,
    input  logic                  ctrl_op_i,
    output logic                  issue_v_o,
    output logic [1:0]            issue_count_o,
    output logic [31:0]           issue_instr_o [2],
    output logic [pc_width_p-1:0] issue_pc_o [2],
    input  logic                  issue_ready_i,
    input  logic                  resolve_i,
    input  logic                  flush_i,
    output logic [31:0]           dual_cnt_o
);
    localparam int cnt_w_lp = $clog2(depth_p) + 1;

    dual_seq_state_e       state_r, state_n;
    logic [cnt_w_lp-1:0]   count;
    logic [31:0]           head_instr [2];
    logic [pc_width_p-1:0] head_pc [2];
    logic                  enq, fire;
    logic [1:0]            pop;

    assign fetch_ready_o = count < cnt_w_lp'(depth_p);
    assign enq           = fetch_v_i & fetch_ready_o & ~flush_i;
    assign pair_v_o      = {count > cnt_w_lp'(1), count != '0};

    assign pair_instr_o[0] = pair_v_o[0] ? head_instr[0] : vanilla_nop_gp;
    assign pair_instr_o[1] = pair_v_o[1] ? head_instr[1] : vanilla_nop_gp;

    assign issue_v_o     = (state_r == eRun) & pair_v_o[0];
    assign issue_count_o = !issue_v_o ? 2'd0
                         : (pair_v_o[1] & ~single_issue_i & ~ctrl_op_i) ? 2'd2 : 2'd1;

    assign issue_instr_o[0] = issue_v_o ? head_instr[0] : vanilla_nop_gp;
    assign issue_instr_o[1] = (issue_count_o == 2'd2) ? head_instr[1] : vanilla_nop_gp;
    assign issue_pc_o[0]    = issue_v_o ? head_pc[0] : '0;
    assign issue_pc_o[1]    = (issue_count_o == 2'd2) ? head_pc[1] : '0;

    // Flush wins over a same-cycle fire: nothing pops and nothing is counted.
    assign fire = issue_v_o & issue_ready_i & ~flush_i;
    assign pop  = fire ? issue_count_o : 2'd0;

    dual_issue_queue #(.depth_p(depth_p), .pc_width_p(pc_width_p)) queue (
        .clk_i        (clk_i),
        .reset_n_i    (reset_n_i),
        .flush_i      (flush_i),
        .enq_i        (enq),
        .instr_i      (fetch_instr_i),
        .pc_i         (fetch_pc_i),
        .pop_i        (pop),
        .count_o      (count),
        .head_instr_o (head_instr),
        .head_pc_o    (head_pc)
    );

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= eRun;
            dual_cnt_o <= '0;
        end else begin
            state_r <= state_n;
            if (fire && issue_count_o == 2'd2)
                dual_cnt_o <= dual_cnt_o + 32'd1;
        end
    end

    always_comb begin
        state_n = state_r;
        if (flush_i)
            state_n = eRun;
        else if (state_r == eRun && fire && ctrl_op_i)
            state_n = eWait;
        else if (state_r == eWait && resolve_i)
            state_n = eRun;
    end
endmodule

// File: tb/tb_dual_issue_sequencer.sv
// tb_dual_issue_sequencer: directed scoreboard bench for dual_issue_sequencer;
// accepted fetches are queued as expectations and checked against each fire.
module tb_dual_issue_sequencer;
    import bsg_vanilla_pkg::*;

    logic        clk = 0, reset_n = 0;
    logic        fetch_v = 0, single_issue = 0, ctrl_op = 0;
    logic        issue_ready = 0, resolve = 0, flush = 0;
    logic [31:0] fetch_instr = 0, fetch_pc = 0;
    logic        fetch_ready, issue_v;
    logic [1:0]  pair_v, issue_count;
    logic [31:0] pair_instr [2];
    logic [31:0] issue_instr [2];
    logic [31:0] issue_pc [2];
    logic [31:0] dual_cnt;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t sb[$];
    int   total = 0, bad = 0;

    always #5 clk = ~clk;

    dual_issue_sequencer #(.depth_p(4), .pc_width_p(32)) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n),
        .fetch_v_i      (fetch_v),
        .fetch_instr_i  (fetch_instr),
        .fetch_pc_i     (fetch_pc),
        .fetch_ready_o  (fetch_ready),
        .pair_instr_o   (pair_instr),
        .pair_v_o       (pair_v),
        .single_issue_i (single_issue),
        .ctrl_op_i      (ctrl_op),
        .issue_v_o      (issue_v),
        .issue_count_o  (issue_count),
        .issue_instr_o  (issue_instr),
        .issue_pc_o     (issue_pc),
        .issue_ready_i  (issue_ready),
        .resolve_i      (resolve),
        .flush_i        (flush),
        .dual_cnt_o     (dual_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] i, input logic [31:0] p, input bit accepted);
        fetch_v     = 1;
        fetch_instr = i;
        fetch_pc    = p;
        if (accepted) sb.push_back({i, p});
    endtask

    task automatic put(input logic [31:0] i, input logic [31:0] p);
        drive(i, p, 1);
        tick();
        fetch_v = 0;
    endtask

    // Offers must match the scoreboard head(s); the accepted entries then retire.
    task automatic fire(input string tag, input int n);
        ent_t e0, e1;
        issue_ready = 1;
        #1;
        e0 = sb[0];
        e1.instr = vanilla_nop_gp;
        e1.pc    = '0;
        if (n == 2) e1 = sb[1];
        chk({tag, "_v"}, 64'(issue_v), 64'd1);
        chk({tag, "_cnt"}, 64'(issue_count), 64'(n));
        chk({tag, "_i0"}, {issue_pc[0], issue_instr[0]}, {e0.pc, e0.instr});
        chk({tag, "_i1"}, {issue_pc[1], issue_instr[1]}, {e1.pc, e1.instr});
        tick();
        issue_ready = 0;
        fetch_v     = 0;
        repeat (n) void'(sb.pop_front());
    endtask

    initial begin
        #12;
        chk("rst_ready", 64'(fetch_ready), 64'd1);
        chk("rst_v", {62'd0, issue_count}, 64'd0);
        chk("rst_issue_v", 64'(issue_v), 64'd0);
        chk("rst_pair_v", 64'(pair_v), 64'd0);
        chk("rst_pair0", 64'(pair_instr[0]), 64'h13);
        chk("rst_issue", {issue_pc[0], issue_instr[0]}, 64'h13);
        chk("rst_dual", 64'(dual_cnt), 64'd0);
        reset_n = 1;
        tick();

        // Basic dual issue, with the one-cycle fetch-to-issue latency.
        drive(32'hA0000001, 32'h100, 1);
        #1 chk("lat_empty", 64'(issue_v), 64'd0);
        tick();
        chk("lat_one", {62'd0, pair_v}, 64'b01);
        drive(32'hB0000002, 32'h104, 1);
        tick();
        fetch_v = 0;
        #1 chk("pair_v11", 64'(pair_v), 64'b11);
        fire("dual", 2);
        chk("dual_cnt1", 64'(dual_cnt), 64'd1);
        chk("empty_after", 64'(issue_v), 64'd0);

        // Single issue followed by a lone tail entry.
        put(32'hC0000003, 32'h108);
        put(32'hD0000004, 32'h10C);
        single_issue = 1;
        fire("single0", 1);
        chk("tail_pair_v", 64'(pair_v), 64'b01);
        chk("tail_nop", 64'(pair_instr[1]), 64'h13);
        fire("single1", 1);
        single_issue = 0;
        chk("dual_cnt_s", 64'(dual_cnt), 64'd1);

        // Control op stalls issue until resolve.
        put(32'hE0000005, 32'h110);
        put(32'hF0000006, 32'h114);
        put(32'h10000007, 32'h118);
        ctrl_op = 1;
        fire("ctrl", 1);
        ctrl_op     = 0;
        issue_ready = 1;
        for (int c = 0; c < 3; c++) begin
            chk($sformatf("wait%0d", c), 64'(issue_v), 64'd0);
            tick();
        end
        chk("wait_pending", 64'(pair_v), 64'b11);
        resolve = 1;
        tick();
        resolve = 0;
        fire("post_resolve", 2);
        chk("dual_cnt2", 64'(dual_cnt), 64'd2);

        // Full queue, a dropped fetch while full, then wrapped refills.
        for (int k = 0; k < 4; k++) put(32'h20000000 + 32'(k), 32'h100 + 32'(4 * k));
        chk("full_ready", 64'(fetch_ready), 64'd0);
        drive(32'hDEADBEEF, 32'h999, 0);
        fire("full_pop", 2);
        drive(32'h20000004, 32'h110, 1);
        fire("wrap_a", 2);
        put(32'h20000005, 32'h114);
        drive(32'h20000006, 32'h118, 1);
        fire("wrap_b", 2);
        put(32'h20000007, 32'h11C);
        fire("wrap_c", 2);
        chk("dual_cnt6", 64'(dual_cnt), 64'd6);

        // Flush with three entries held in WAIT, alongside a fetch and resolve.
        for (int k = 0; k < 4; k++) put(32'h30000000 + 32'(k), 32'h200 + 32'(4 * k));
        ctrl_op = 1;
        fire("pre_flush", 1);
        ctrl_op = 0;
        chk("flush_wait", 64'(issue_v), 64'd0);
        drive(32'h3FFFFFFF, 32'h2F0, 0);
        flush   = 1;
        resolve = 1;
        tick();
        flush   = 0;
        resolve = 0;
        fetch_v = 0;
        sb.delete();
        chk("flush_pair_v", 64'(pair_v), 64'd0);
        chk("flush_ready", 64'(fetch_ready), 64'd1);
        chk("flush_dual", 64'(dual_cnt), 64'd6);
        put(32'h40000000, 32'h300);
        fire("after_flush", 1);

        // Asynchronous reset between clock edges mid dual-issue.
        put(32'h50000000, 32'h400);
        put(32'h50000001, 32'h404);
        chk("pre_rst_cnt", 64'(issue_count), 64'd2);
        #2 reset_n = 0;
        #1;
        chk("arst_issue_v", 64'(issue_v), 64'd0);
        chk("arst_count", 64'(issue_count), 64'd0);
        chk("arst_pair_v", 64'(pair_v), 64'd0);
        chk("arst_dual", 64'(dual_cnt), 64'd0);
        chk("arst_ready", 64'(fetch_ready), 64'd1);
        chk("arst_issue", {issue_pc[0], issue_instr[0]}, 64'h13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
